// File: rtl/cmos_emu.sv
// MC146818-style CMOS/RTC model: 256-byte register space, BCD 24 h clock/calendar in 0x00-0x09.
// Single-cycle read/write accesses; reads are registered and held until the next read.
module cmos_emu #(
  parameter int TICKS_PER_SEC = 3500000
) (
  input  logic       zclk,
  input  logic       rst,
  input  logic       cmos_req,
  input  logic       cmos_rnw,
  input  logic [7:0] cmos_addr,
  input  logic [7:0] cmos_write,
  output logic [7:0] cmos_read
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_reg;
  logic          pending_reg;
  logic [7:0]    sec_reg, min_reg, hour_reg, dow_reg, date_reg, month_reg, year_reg;
  logic [6:0]    reg_a_reg;
  logic [7:0]    reg_b_reg;
  logic [7:0]    mem [0:255] = '{default: 8'h00};

  logic       wr_en, rd_en, tick_raw, tick_due, advance, is_ram_addr;
  logic       c_min, c_hour, c_day, c_month, c_year;
  logic [1:0] yr_mod4;
  logic [7:0] month_last, read_val;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
  endfunction

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] limit,
                                          input logic [7:0] wrap_to);
    return (v == limit) ? wrap_to : bcd_inc(v);
  endfunction

  assign wr_en    = cmos_req & ~cmos_rnw;
  assign rd_en    = cmos_req & cmos_rnw;
  assign tick_raw = (presc_reg == PRESC_MAX);
  // A tick colliding with a write waits for the next write-free cycle.
  assign tick_due = (tick_raw | pending_reg) & ~wr_en;
  assign advance  = tick_due & ~reg_b_reg[7];

  // tens*10 mod 4 == (tens odd ? 2 : 0), so only tens[0] matters.
  assign yr_mod4 = year_reg[1:0] + {year_reg[4], 1'b0};

  always_comb begin
    month_last = 8'h31;
    case (month_reg)
      8'h02:                      month_last = (yr_mod4 == 2'd0) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_last = 8'h30;
      default:                    month_last = 8'h31;
    endcase
  end

  assign c_min   = (sec_reg == 8'h59);
  assign c_hour  = c_min & (min_reg == 8'h59);
  assign c_day   = c_hour & (hour_reg == 8'h23);
  assign c_month = c_day & (date_reg == month_last);
  assign c_year  = c_month & (month_reg == 8'h12);

  assign is_ram_addr = (cmos_addr == 8'h01) || (cmos_addr == 8'h03) ||
                       (cmos_addr == 8'h05) || (cmos_addr >= 8'h0E);

  always_comb begin
    read_val = 8'h00;
    case (cmos_addr)
      8'h00:   read_val = sec_reg;
      8'h02:   read_val = min_reg;
      8'h04:   read_val = hour_reg;
      8'h06:   read_val = dow_reg;
      8'h07:   read_val = date_reg;
      8'h08:   read_val = month_reg;
      8'h09:   read_val = year_reg;
      8'h0A:   read_val = {1'b0, reg_a_reg};
      8'h0B:   read_val = reg_b_reg;
      8'h0C:   read_val = 8'h00;
      8'h0D:   read_val = 8'h80;
      default: read_val = mem[cmos_addr];
    endcase
  end

  // RAM and alarm bytes survive reset.
  always_ff @(posedge zclk) begin
    if (!rst && wr_en && is_ram_addr)
      mem[cmos_addr] <= cmos_write;
  end

  always_ff @(posedge zclk) begin
    if (rst) begin
      cmos_read   <= 8'h00;
      presc_reg   <= '0;
      pending_reg <= 1'b0;
      sec_reg     <= 8'h00;
      min_reg     <= 8'h00;
      hour_reg    <= 8'h00;
      dow_reg     <= 8'h01;
      date_reg    <= 8'h01;
      month_reg   <= 8'h01;
      year_reg    <= 8'h00;
      reg_a_reg   <= 7'h00;
      reg_b_reg   <= 8'h02;
    end else begin
      if (rd_en)
        cmos_read <= read_val;

      if (wr_en && cmos_addr == 8'h00)
        presc_reg <= '0;
      else if (tick_raw)
        presc_reg <= '0;
      else
        presc_reg <= presc_reg + 1'b1;

      pending_reg <= wr_en & (tick_raw | pending_reg);

      if (wr_en) begin
        case (cmos_addr)
          8'h00:   sec_reg   <= cmos_write;
          8'h02:   min_reg   <= cmos_write;
          8'h04:   hour_reg  <= cmos_write;
          8'h06:   dow_reg   <= cmos_write;
          8'h07:   date_reg  <= cmos_write;
          8'h08:   month_reg <= cmos_write;
          8'h09:   year_reg  <= cmos_write;
          8'h0A:   reg_a_reg <= cmos_write[6:0];
          8'h0B:   reg_b_reg <= cmos_write;
          default: ;
        endcase
      end else if (advance) begin
        sec_reg <= bcd_step(sec_reg, 8'h59, 8'h00);
        if (c_min)   min_reg   <= bcd_step(min_reg, 8'h59, 8'h00);
        if (c_hour)  hour_reg  <= bcd_step(hour_reg, 8'h23, 8'h00);
        if (c_day)   dow_reg   <= bcd_step(dow_reg, 8'h07, 8'h01);
        if (c_day)   date_reg  <= bcd_step(date_reg, month_last, 8'h01);
        if (c_month) month_reg <= bcd_step(month_reg, 8'h12, 8'h01);
        if (c_year)  year_reg  <= bcd_step(year_reg, 8'h99, 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_cmos_emu.sv
// Directed bench for cmos_emu with a 4-cycle second; expected values are hand-computed.
`timescale 1ns/1ps
module tb_cmos_emu;

  logic       zclk = 1'b0;
  logic       rst = 1'b1;
  logic       cmos_req = 1'b0;
  logic       cmos_rnw = 1'b1;
  logic [7:0] cmos_addr = 8'h00;
  logic [7:0] cmos_write = 8'h00;
  logic [7:0] cmos_read;

  int n_cmp = 0;
  int n_err = 0;

  cmos_emu #(.TICKS_PER_SEC(4)) dut (
    .zclk(zclk),
    .rst(rst),
    .cmos_req(cmos_req),
    .cmos_rnw(cmos_rnw),
    .cmos_addr(cmos_addr),
    .cmos_write(cmos_write),
    .cmos_read(cmos_read)
  );

  always #5 zclk = ~zclk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end else begin
      $display("ok   %s: %02h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge zclk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cmos_req = 1'b1; cmos_rnw = 1'b0; cmos_addr = a; cmos_write = d;
    @(posedge zclk);
    #1;
    cmos_req = 1'b0; cmos_rnw = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    cmos_req = 1'b1; cmos_rnw = 1'b1; cmos_addr = a;
    @(posedge zclk);
    #1;
    cmos_req = 1'b0;
    chk(tag, cmos_read, exp);
  endtask

  // Reset with a write request asserted; the write must be suppressed.
  task automatic do_reset();
    rst = 1'b1;
    cmos_req = 1'b1; cmos_rnw = 1'b0; cmos_addr = 8'h3F; cmos_write = 8'h99;
    idle(2);
    rst = 1'b0;
    cmos_req = 1'b0; cmos_rnw = 1'b1;
    chk("reset_cmos_read", cmos_read, 8'h00);
  endtask

  // Loads the clock frozen, ends with the sec write two edges back;
  // the first tick lands on the second edge after this task returns.
  task automatic set_clock(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                           input logic [7:0] dw, input logic [7:0] dt, input logic [7:0] mo,
                           input logic [7:0] yr);
    wr(8'h0B, 8'h82);
    wr(8'h02, m);
    wr(8'h04, h);
    wr(8'h06, dw);
    wr(8'h07, dt);
    wr(8'h08, mo);
    wr(8'h09, yr);
    wr(8'h00, s);
    idle(1);
    wr(8'h0B, 8'h02);
  endtask

  initial begin
    do_reset();
    rd_chk("rst_sec", 8'h00, 8'h00);
    rd_chk("rst_dow", 8'h06, 8'h01);
    rd_chk("rst_date", 8'h07, 8'h01);
    rd_chk("rst_regb", 8'h0B, 8'h02);
    rd_chk("rst_regd", 8'h0D, 8'h80);
    rd_chk("rst_rega", 8'h0A, 8'h00);
    rd_chk("rst_min", 8'h02, 8'h00);
    rd_chk("rst_hour", 8'h04, 8'h00);
    rd_chk("rst_month", 8'h08, 8'h01);
    rd_chk("rst_year", 8'h09, 8'h00);

    wr(8'h0A, 8'hFF);
    rd_chk("rega_uip_zero", 8'h0A, 8'h7F);
    wr(8'h01, 8'h33);
    rd_chk("alarm_storage", 8'h01, 8'h33);

    // Full carry chain: 99-12-31 23:59:59, dow 7
    set_clock(8'h59, 8'h59, 8'h23, 8'h07, 8'h31, 8'h12, 8'h99);
    idle(1);
    rd_chk("read_on_tick_pre", 8'h00, 8'h59);
    rd_chk("roll_sec", 8'h00, 8'h00);
    rd_chk("roll_min", 8'h02, 8'h00);
    rd_chk("roll_hour", 8'h04, 8'h00);
    rd_chk("roll_date", 8'h07, 8'h01);
    rd_chk("roll_month", 8'h08, 8'h01);
    rd_chk("roll_year", 8'h09, 8'h00);
    rd_chk("roll_dow", 8'h06, 8'h01);

    set_clock(8'h59, 8'h59, 8'h23, 8'h03, 8'h28, 8'h02, 8'h24);
    idle(2);
    rd_chk("leap_date", 8'h07, 8'h29);
    rd_chk("leap_month", 8'h08, 8'h02);

    set_clock(8'h59, 8'h59, 8'h23, 8'h03, 8'h30, 8'h04, 8'h24);
    idle(2);
    rd_chk("apr_date", 8'h07, 8'h01);
    rd_chk("apr_month", 8'h08, 8'h05);

    set_clock(8'h59, 8'h59, 8'h23, 8'h03, 8'h28, 8'h02, 8'h23);
    idle(2);
    rd_chk("noleap_date", 8'h07, 8'h01);
    rd_chk("noleap_month", 8'h08, 8'h03);

    // Freeze: sec is 00 here; 40 cycles would otherwise advance it to 10
    wr(8'h0B, 8'h82);
    idle(40);
    rd_chk("set_frozen_sec", 8'h00, 8'h00);
    wr(8'h0B, 8'h02);
    idle(3);
    rd_chk("set_resumed_sec", 8'h00, 8'h01);

    // Write on the tick edge defers the increment by one cycle
    set_clock(8'h10, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00);
    idle(1);
    wr(8'h20, 8'hAB);
    rd_chk("pend_late_sec", 8'h00, 8'h10);
    rd_chk("pend_applied_sec", 8'h00, 8'h11);
    rd_chk("pend_once_sec", 8'h00, 8'h11);
    rd_chk("pend_ram_write", 8'h20, 8'hAB);

    wr(8'h3F, 8'h55);
    rd_chk("ram_rw", 8'h3F, 8'h55);
    do_reset();
    rd_chk("ram_keeps_reset", 8'h3F, 8'h55);
    wr(8'h0C, 8'h5A);
    rd_chk("regc_ignored", 8'h0C, 8'h00);
    wr(8'h0D, 8'h00);
    rd_chk("regd_ignored", 8'h0D, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
